piso_mux_serializer: RTL
========================

PISO_MUX_SERIALIZER -- requirements
Module: piso_mux_serializer

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0: 0 sends select index 0..7 in order, 1 sends 7..0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port din, input, 8, the parallel word to serialize.
REQ-005 The block SHALL have port din_valid, input, 1, meaning din is offered.
REQ-006 The block SHALL have port din_ready, output, 1; a word is accepted on a clk edge where din_valid and din_ready are both 1.
REQ-007 The block SHALL have port data_q, output, 8, the held word, driving the 8:1 mux data input i[7:0].
REQ-008 The block SHALL have port sel, output, 3, driving the 8:1 mux select.
REQ-009 The block SHALL have port mux_y, input, 1, the 8:1 mux output, equal to data_q[sel].
REQ-010 The block SHALL have port ser_out, output, 1, the registered serial bit.
REQ-011 The block SHALL have port ser_valid, output, 1, meaning ser_out is valid.
REQ-012 The block SHALL have port ser_ready, input, 1; a bit transfers on a clk edge where ser_valid and ser_ready are both 1.
REQ-013 The block SHALL have port ser_last, output, 1, marking the final bit of a frame; it is qualified by ser_valid.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and LAST; with PAR_SER_PARITY_EN it also has state PARITY.
REQ-015 din_ready SHALL be 1 only in IDLE; no word is accepted in any other state.
REQ-016 On accept, the block SHALL load data_q<=din, set sel to the start index (0, or 7 when MSB_FIRST=1), clear ser_valid, and enter SHIFT.
REQ-017 The output register SHALL be loadable (load condition) on any edge where !ser_valid || ser_ready holds.
REQ-018 In SHIFT, on each edge where the load condition holds, the block SHALL set ser_out<=mux_y and ser_valid<=1.
REQ-019 On that same edge in SHIFT, sel SHALL step by +1, or by -1 when MSB_FIRST=1.
REQ-020 When the bit at the end index (7, or 0 when MSB_FIRST=1) is captured, sel SHALL hold, ser_last<=1, and the FSM SHALL enter LAST; without the macro, this is the frame end.
REQ-021 In LAST, on a transfer, the FSM SHALL go to IDLE and clear ser_valid and ser_last; sel SHALL return to the start index.
REQ-022 With ser_ready held 1, the block SHALL transfer 8 consecutive bits on the edges after accept edges E+2..E+9, return to IDLE at E+9, and next accept at E+10 at the earliest.
REQ-023 With ser_ready=0 and ser_valid=1, ser_out, ser_last and sel SHALL hold, with no bit loss or duplication.
REQ-024 data_q SHALL be stable from accept until return to IDLE; changes on din while the block is not in IDLE SHALL be ignored.
REQ-025 sel SHALL never leave 0..7, with no wrap past the end index.

Reset
REQ-026 While rst=1 at an edge, the block SHALL force state IDLE, sel=0 (7 if MSB_FIRST=1), data_q=0, ser_out=0, ser_valid=0 and ser_last=0.
REQ-027 rst SHALL take priority over any handshake on the same edge.
REQ-028 rst mid-frame SHALL abandon the frame, with no partial bits emitted afterwards.
REQ-029 din_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro PAR_SER_PARITY_EN SHALL control the parity feature.
REQ-031 When PAR_SER_PARITY_EN is defined, capture of the end-index bit SHALL enter PARITY with ser_last=0.
REQ-032 In PARITY, on the load condition, the block SHALL set ser_out<=^data_q (even parity), ser_last<=1 and go to LAST; a frame is then 9 bits and the back-to-back period is 11 cycles.
REQ-033 When PAR_SER_PARITY_EN is not defined, no PARITY state or logic SHALL exist and a frame is 8 bits.

Verification
REQ-034 Bench: reset, din=8'hA5, valid 1 cycle, ser_ready=1 -> bits 1,0,1,0,0,1,0,1, ser_last on 8th bit, din_ready high again 9 edges after accept.
REQ-035 Bench: MSB_FIRST=1, din=8'h81 -> bits 1,0,0,0,0,0,0,1; sel sequence 7..0.
REQ-036 Bench: din=8'h3C, ser_ready toggled 1,0,0,1 repeating -> serial stream still 0,0,1,1,1,1,0,0, sel held during stalls.
REQ-037 Bench: rst asserted after 3 bits of 8'hFF -> next cycle ser_valid=0, din_ready=1; next word 8'h01 serializes correctly.
REQ-038 Bench with PAR_SER_PARITY_EN: din=8'h07 -> 9 bits, 9th=1 with ser_last; din=8'h03 -> 9th=0.
REQ-039 Bench: din_valid held high with words 8'h11, 8'h22 -> accepts spaced 10 cycles (11 with parity), din changes mid-frame ignored.

Source files
------------

// File: rtl/piso_mux_serializer.sv
// piso_mux_serializer: parallel-in/serial-out controller that walks an
// external 8:1 mux. The held word (data_q) drives the mux data inputs, sel
// drives its select, and the mux output (mux_y) is captured into a
// registered serial output under a valid/ready handshake.
//
// Optional feature: define PAR_SER_PARITY_EN to append an even-parity bit
// to every frame (9-bit frames, 11-cycle back-to-back period).
// Without it, frames are 8 bits and the back-to-back period is 10 cycles.
module piso_mux_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [7:0] data_q,
   output logic [2:0] sel,
   input  logic       mux_y,
   output logic       ser_out,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_last
);

   // First and final mux index of a frame, fixed by bit order.
   localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

`ifdef PAR_SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, LAST, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, LAST} state_t;
`endif

   state_t state;

   logic accept;   // parallel word taken this edge
   logic load;     // output register free to take a new bit
   logic xfer;     // serial bit consumed downstream this edge

   assign accept = din_valid && din_ready;
   assign load   = !ser_valid || ser_ready;
   assign xfer   = ser_valid && ser_ready;

   // Control FSM with all outputs registered; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= START_IDX;
         data_q    <= 8'h00;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         ser_last  <= 1'b0;
         din_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q    <= din;
                  sel       <= START_IDX;
                  ser_valid <= 1'b0;
                  ser_last  <= 1'b0;
                  din_ready <= 1'b0;
                  state     <= SHIFT;
               end
            end

            SHIFT: begin
               if (load) begin
                  ser_out   <= mux_y;
                  ser_valid <= 1'b1;
                  if (sel == END_IDX) begin
                     // Final data bit: sel parks on the end index.
`ifdef PAR_SER_PARITY_EN
                     ser_last <= 1'b0;
                     state    <= PARITY;
`else
                     ser_last <= 1'b1;
                     state    <= LAST;
`endif
                  end else if (MSB_FIRST) begin
                     sel <= sel - 3'd1;
                  end else begin
                     sel <= sel + 3'd1;
                  end
               end
            end

`ifdef PAR_SER_PARITY_EN
            PARITY: begin
               // Even parity over the held word closes the frame.
               if (load) begin
                  ser_out   <= ^data_q;
                  ser_valid <= 1'b1;
                  ser_last  <= 1'b1;
                  state     <= LAST;
               end
            end
`endif

            LAST: begin
               // Wait for the closing bit to be taken, then rearm.
               if (xfer) begin
                  ser_valid <= 1'b0;
                  ser_last  <= 1'b0;
                  sel       <= START_IDX;
                  din_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               sel       <= START_IDX;
               ser_valid <= 1'b0;
               ser_last  <= 1'b0;
               din_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
